// File: rtl/stage_ex_md.sv
// ----------------------------------------------------------------------------
// stage_ex_md
// Execute stage for the in-order core. It performs operand forwarding, the
// ALU, the branch target and the branch decision. It also contains an
// iterative RV32M/RV64M multiply/divide unit that stalls the pipeline while
// it runs.
//
// Parameters
//   XLEN    datapath width (32 or 64)
//   UNROLL  multiply/divide bits retired per cycle (1, 2, 4 or 8; divides XLEN)
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   ex_pc, ex_imm                 PC and sign-extended immediate of the EX instruction
//   ex_regs_data1/2               register-file operands
//   ex_func3_code, ex_func7_code  func3 and func7[5]
//   ex_alu_op                     ALU class: 0 add, 1 branch, 2 R-type, 3 I-type, 4 jump
//   ex_alu_src1/2                 operand A (rs1/PC/0) and operand B (rs2/imm/4) select
//   ex_br_addr_mode               branch base: 0 PC, 1 forwarded rs1 (JALR)
//   ex_br, ex_md_req, ex_flush    branch/jump, M-extension op, kill EX instruction
//   forwardA/B                    00 register file, 10 EX/MEM, 01 MEM/WB
//   me_alu_o, w_regs_data         forwarding values from EX/MEM and MEM/WB
//   ex_alu_o                      ALU result, or the M result in DONE
//   ex_regs_data2_o               forwarded rs2 (store data)
//   br_pc, br_ctrl                branch target and branch-taken
//   ex_stall                      hold IF/ID/EX, bubble into EX/MEM
// ----------------------------------------------------------------------------
module stage_ex_md #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_regs_data1,
    input  logic [XLEN-1:0] ex_regs_data2,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [2:0]      ex_func3_code,
    input  logic            ex_func7_code,
    input  logic [2:0]      ex_alu_op,
    input  logic [1:0]      ex_alu_src1,
    input  logic [1:0]      ex_alu_src2,
    input  logic            ex_br_addr_mode,
    input  logic            ex_br,
    input  logic            ex_md_req,
    input  logic            ex_flush,
    input  logic [1:0]      forwardA,
    input  logic [1:0]      forwardB,
    input  logic [XLEN-1:0] me_alu_o,
    input  logic [XLEN-1:0] w_regs_data,
    output logic [XLEN-1:0] ex_alu_o,
    output logic [XLEN-1:0] ex_regs_data2_o,
    output logic [XLEN-1:0] br_pc,
    output logic            br_ctrl,
    output logic            ex_stall
);

    localparam int STEPS = XLEN / UNROLL;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam int SH_W  = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] ALU_OP_ADD    = 3'd0;
    localparam logic [2:0] ALU_OP_BRANCH = 3'd1;
    localparam logic [2:0] ALU_OP_RTYPE  = 3'd2;
    localparam logic [2:0] ALU_OP_ITYPE  = 3'd3;
    localparam logic [2:0] ALU_OP_JUMP   = 3'd4;

    typedef enum logic [3:0] {
        FN_ADD, FN_SUB, FN_SLL, FN_SLT, FN_SLTU,
        FN_XOR, FN_SRL, FN_SRA, FN_OR, FN_AND
    } alu_fn_e;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

    // ------------------------------------------------------------------
    // Forwarding and operand selection
    // ------------------------------------------------------------------
    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_result;
    logic [SH_W-1:0] shamt;
    alu_fn_e         alu_fn;
    logic            br_mark;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case statements can infer a latch.
    always_comb begin
        fwd_a = ex_regs_data1;
        fwd_b = ex_regs_data2;
        case (forwardA)
            2'b10:   fwd_a = me_alu_o;
            2'b01:   fwd_a = w_regs_data;
            default: fwd_a = ex_regs_data1;
        endcase
        case (forwardB)
            2'b10:   fwd_b = me_alu_o;
            2'b01:   fwd_b = w_regs_data;
            default: fwd_b = ex_regs_data2;
        endcase
    end

    always_comb begin
        op_a = fwd_a;
        op_b = fwd_b;
        case (ex_alu_src1)
            2'd1:    op_a = ex_pc;
            2'd2:    op_a = '0;
            default: op_a = fwd_a;
        endcase
        case (ex_alu_src2)
            2'd1:    op_b = ex_imm;
            2'd2:    op_b = XLEN'(4);
            default: op_b = fwd_b;
        endcase
    end

    assign shamt = op_b[SH_W-1:0];

    // alu_control: func7[5] only selects SUB for R-type, and SRA for shifts.
    always_comb begin
        alu_fn = FN_ADD;
        case (ex_alu_op)
            ALU_OP_BRANCH: alu_fn = FN_SUB;
            ALU_OP_RTYPE, ALU_OP_ITYPE: begin
                case (ex_func3_code)
                    3'b000:  alu_fn = (ex_alu_op == ALU_OP_RTYPE && ex_func7_code) ? FN_SUB : FN_ADD;
                    3'b001:  alu_fn = FN_SLL;
                    3'b010:  alu_fn = FN_SLT;
                    3'b011:  alu_fn = FN_SLTU;
                    3'b100:  alu_fn = FN_XOR;
                    3'b101:  alu_fn = ex_func7_code ? FN_SRA : FN_SRL;
                    3'b110:  alu_fn = FN_OR;
                    default: alu_fn = FN_AND;
                endcase
            end
            default: alu_fn = FN_ADD;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_fn)
            FN_ADD:  alu_result = op_a + op_b;
            FN_SUB:  alu_result = op_a - op_b;
            FN_SLL:  alu_result = op_a << shamt;
            FN_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            FN_SLTU: alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            FN_XOR:  alu_result = op_a ^ op_b;
            FN_SRL:  alu_result = op_a >> shamt;
            FN_SRA:  alu_result = $signed(op_a) >>> shamt;
            FN_OR:   alu_result = op_a | op_b;
            default: alu_result = op_a & op_b;
        endcase
    end

    // ------------------------------------------------------------------
    // Branch decision and target
    // ------------------------------------------------------------------
    always_comb begin
        br_mark = 1'b0;
        if (ex_alu_op == ALU_OP_JUMP) begin
            br_mark = 1'b1;
        end else if (ex_alu_op == ALU_OP_BRANCH) begin
            case (ex_func3_code)
                3'b000:  br_mark = (fwd_a == fwd_b);
                3'b001:  br_mark = (fwd_a != fwd_b);
                3'b100:  br_mark = ($signed(fwd_a) <  $signed(fwd_b));
                3'b101:  br_mark = ($signed(fwd_a) >= $signed(fwd_b));
                3'b110:  br_mark = (fwd_a <  fwd_b);
                3'b111:  br_mark = (fwd_a >= fwd_b);
                default: br_mark = 1'b0;
            endcase
        end
    end

    logic [XLEN-1:0] br_sum;
    assign br_sum  = (ex_br_addr_mode ? fwd_a : ex_pc) + ex_imm;
    assign br_pc   = {br_sum[XLEN-1:1], br_sum[0] & ~ex_br_addr_mode};
    assign br_ctrl = br_mark & ex_br & ~ex_md_req & ~ex_flush;

    // ------------------------------------------------------------------
    // Multiply/divide unit
    // ------------------------------------------------------------------
    md_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]      f3_q;
    logic            a_neg_q, b_neg_q;
    logic [XLEN-1:0] b_mag_q, hi_q, lo_q, result_q;

    // Operand decode at accept time, straight from the forwarded values.
    logic            md_accept, is_div, a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, fast_result;

    assign md_accept = (state_q == MD_IDLE) & ex_md_req & ~ex_flush;
    assign is_div    = ex_func3_code[2];
    // MUL/MULH/MULHSU treat rs1 as signed, MUL/MULH treat rs2 as signed;
    // for divides bit 0 of func3 marks the unsigned variants.
    assign a_signed  = is_div ? ~ex_func3_code[0] : (ex_func3_code != 3'b011);
    assign b_signed  = is_div ? ~ex_func3_code[0] : ~ex_func3_code[1];
    assign a_neg     = a_signed & fwd_a[XLEN-1];
    assign b_neg     = b_signed & fwd_b[XLEN-1];
    assign a_mag     = a_neg ? -fwd_a : fwd_a;
    assign b_mag     = b_neg ? -fwd_b : fwd_b;
    assign div_zero  = is_div & (fwd_b == '0);
    assign div_ovf   = is_div & ~ex_func3_code[0] & (fwd_a == MOST_NEG) & (fwd_b == '1);
    // func3[1] separates remainder from quotient for the fast-path results.
    assign fast_result = div_zero ? (ex_func3_code[1] ? fwd_a : '1)
                                  : (ex_func3_code[1] ? '0 : MOST_NEG);

    // UNROLL iterations of shift-add (multiply) or restoring divide.
    // Multiply: hi:lo holds partial product : remaining multiplier bits.
    // Divide:   hi:lo holds partial remainder : dividend/quotient bits.
    logic [XLEN-1:0] hi_n, lo_n;
    logic [XLEN:0]   step_sum, rem_sh;

    // NOTE: blocking assignments are used here because each unrolled
    // iteration must see the value produced by the previous one within the
    // same cycle; the registers themselves are only written with <=.
    always_comb begin
        hi_n     = hi_q;
        lo_n     = lo_q;
        step_sum = '0;
        rem_sh   = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (f3_q[2]) begin
                rem_sh = {hi_n, lo_n[XLEN-1]};
                lo_n   = {lo_n[XLEN-2:0], 1'b0};
                if (rem_sh >= {1'b0, b_mag_q}) begin
                    rem_sh  = rem_sh - {1'b0, b_mag_q};
                    lo_n[0] = 1'b1;
                end
                hi_n = rem_sh[XLEN-1:0];
            end else begin
                step_sum = {1'b0, hi_n} + (lo_n[0] ? {1'b0, b_mag_q} : {(XLEN+1){1'b0}});
                lo_n     = {step_sum[0], lo_n[XLEN-1:1]};
                hi_n     = step_sum[XLEN:1];
            end
        end
    end

    // Sign correction of the final magnitude result.
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, md_final;

    always_comb begin
        prod_s = (a_neg_q ^ b_neg_q) ? -{hi_n, lo_n} : {hi_n, lo_n};
        quo_s  = (a_neg_q ^ b_neg_q) ? -lo_n : lo_n;
        rem_s  = a_neg_q ? -hi_n : hi_n;
        case (f3_q)
            3'b000:         md_final = prod_s[XLEN-1:0];
            3'b100, 3'b101: md_final = quo_s;
            3'b110, 3'b111: md_final = rem_s;
            default:        md_final = prod_s[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (md_accept) state_d = (div_zero | div_ovf) ? MD_DONE : MD_BUSY;
            MD_BUSY: begin
                if (ex_flush)                    state_d = MD_IDLE;
                else if (cnt_q == CNT_W'(1))     state_d = MD_DONE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= MD_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            f3_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_mag_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md_accept) begin
                        f3_q    <= ex_func3_code;
                        a_neg_q <= a_neg;
                        b_neg_q <= b_neg;
                        b_mag_q <= b_mag;
                        hi_q    <= '0;
                        lo_q    <= a_mag;
                        if (div_zero | div_ovf) begin
                            result_q <= fast_result;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q    <= CNT_W'(STEPS);
                        end
                    end
                end
                MD_BUSY: begin
                    if (ex_flush) begin
                        cnt_q <= '0;
                    end else begin
                        hi_q  <= hi_n;
                        lo_q  <= lo_n;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) result_q <= md_final;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ex_alu_o        = (state_q == MD_DONE) ? result_q : alu_result;
    assign ex_regs_data2_o = fwd_b;
    // Reset is folded in so the IDLE-accept term cannot raise a stall
    // while the block is held in reset.
    assign ex_stall = rstn & (md_accept | ((state_q == MD_BUSY) & ~ex_flush));

endmodule

// File: tb/tb_stage_ex_md.sv
// ----------------------------------------------------------------------------
// tb_stage_ex_md
// Directed bench for stage_ex_md. Three instances: XLEN=32/UNROLL=1 (u1),
// XLEN=32/UNROLL=4 (u4, same inputs as u1) and XLEN=64/UNROLL=1 (u64).
// M results are predicted when an operation is issued, queued, and compared
// together with the observed stall count once the unit drops ex_stall.
// ----------------------------------------------------------------------------
module tb_stage_ex_md;

    typedef struct {
        logic [63:0] value;
        int          stalls;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        clk, rstn;
    logic [31:0] pc, rd1, rd2, imm, me_alu, w_data;
    logic [2:0]  f3, alu_op;
    logic        f7, mode, br, md_req, flush;
    logic [1:0]  src1, src2, fa, fb;

    logic [31:0] u1_alu_o, u1_rd2_o, u1_br_pc, u4_alu_o, u4_rd2_o, u4_br_pc;
    logic        u1_br_ctrl, u1_stall, u4_br_ctrl, u4_stall;

    logic [63:0] rs1_64, rs2_64, z64, u64_alu_o, u64_rd2_o, u64_br_pc;
    logic [2:0]  f3_64, z3;
    logic [1:0]  z2;
    logic        md_req64, z1, u64_br_ctrl, u64_stall;

    stage_ex_md #(.XLEN(32), .UNROLL(1)) u1 (
        .clk(clk), .rstn(rstn), .ex_pc(pc), .ex_regs_data1(rd1), .ex_regs_data2(rd2),
        .ex_imm(imm), .ex_func3_code(f3), .ex_func7_code(f7), .ex_alu_op(alu_op),
        .ex_alu_src1(src1), .ex_alu_src2(src2), .ex_br_addr_mode(mode), .ex_br(br),
        .ex_md_req(md_req), .ex_flush(flush), .forwardA(fa), .forwardB(fb),
        .me_alu_o(me_alu), .w_regs_data(w_data), .ex_alu_o(u1_alu_o),
        .ex_regs_data2_o(u1_rd2_o), .br_pc(u1_br_pc), .br_ctrl(u1_br_ctrl), .ex_stall(u1_stall)
    );

    stage_ex_md #(.XLEN(32), .UNROLL(4)) u4 (
        .clk(clk), .rstn(rstn), .ex_pc(pc), .ex_regs_data1(rd1), .ex_regs_data2(rd2),
        .ex_imm(imm), .ex_func3_code(f3), .ex_func7_code(f7), .ex_alu_op(alu_op),
        .ex_alu_src1(src1), .ex_alu_src2(src2), .ex_br_addr_mode(mode), .ex_br(br),
        .ex_md_req(md_req), .ex_flush(flush), .forwardA(fa), .forwardB(fb),
        .me_alu_o(me_alu), .w_regs_data(w_data), .ex_alu_o(u4_alu_o),
        .ex_regs_data2_o(u4_rd2_o), .br_pc(u4_br_pc), .br_ctrl(u4_br_ctrl), .ex_stall(u4_stall)
    );

    stage_ex_md #(.XLEN(64), .UNROLL(1)) u64 (
        .clk(clk), .rstn(rstn), .ex_pc(z64), .ex_regs_data1(rs1_64), .ex_regs_data2(rs2_64),
        .ex_imm(z64), .ex_func3_code(f3_64), .ex_func7_code(z1), .ex_alu_op(z3),
        .ex_alu_src1(z2), .ex_alu_src2(z2), .ex_br_addr_mode(z1), .ex_br(z1),
        .ex_md_req(md_req64), .ex_flush(z1), .forwardA(z2), .forwardB(z2),
        .me_alu_o(z64), .w_regs_data(z64), .ex_alu_o(u64_alu_o),
        .ex_regs_data2_o(u64_rd2_o), .br_pc(u64_br_pc), .br_ctrl(u64_br_ctrl), .ex_stall(u64_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic get_stall(input int sel);
        if (sel == 0) return u1_stall;
        if (sel == 1) return u4_stall;
        return u64_stall;
    endfunction

    function automatic logic [63:0] get_out(input int sel);
        if (sel == 0) return {32'h0, u1_alu_o};
        if (sel == 1) return {32'h0, u4_alu_o};
        return u64_alu_o;
    endfunction

    task automatic idle(input int n);
        md_req   = 1'b0;
        md_req64 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Issue one M op, count stall cycles, compare against the queued prediction
    // in the first non-stalled cycle. change_at >= 0 disturbs the forwarding
    // sources after that many stall cycles.
    task automatic run_md(input int sel, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_val,
                          input int exp_stalls, input string tag, input int change_at);
        exp_t e;
        int   n = 0;
        bit   done = 1'b0;
        sb_q.push_back('{exp_val, exp_stalls});
        @(negedge clk);
        if (sel == 2) begin
            md_req64 = 1'b1; f3_64 = op; rs1_64 = a; rs2_64 = b;
        end else begin
            md_req = 1'b1; f3 = op; rd1 = a[31:0]; rd2 = b[31:0];
        end
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            if (get_stall(sel)) begin
                n++;
                if (n == change_at) begin
                    me_alu = 32'd99;
                    rd1    = 32'hDEAD_BEEF;
                end
                @(negedge clk);
            end else begin
                done = 1'b1;
                e = sb_q.pop_front();
                check({tag, " result"}, get_out(sel), e.value);
                check({tag, " stalls"}, 64'(n), 64'(e.stalls));
            end
        end
        if (!done) begin
            void'(sb_q.pop_front());
            check({tag, " completed"}, 64'(done), 64'd1);
        end
        md_req   = 1'b0;
        md_req64 = 1'b0;
    endtask

    initial begin
        int bad;
        rstn = 1'b0;
        pc = '0; rd1 = '0; rd2 = '0; imm = '0; me_alu = '0; w_data = '0;
        f3 = '0; f7 = 1'b0; alu_op = 3'd0; src1 = '0; src2 = '0;
        mode = 1'b0; br = 1'b0; md_req = 1'b0; flush = 1'b0; fa = '0; fb = '0;
        rs1_64 = '0; rs2_64 = '0; f3_64 = '0; md_req64 = 1'b0;
        z64 = '0; z3 = '0; z2 = '0; z1 = 1'b0;

        // Held in reset: stall forced low, ALU still combinational.
        md_req = 1'b1; rd1 = 32'd3; rd2 = 32'd4;
        #2;
        check("reset stall u1", 64'(u1_stall), 64'd0);
        check("reset stall u4", 64'(u4_stall), 64'd0);
        check("reset alu", 64'(u1_alu_o), 64'd7);
        md_req = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        run_md(0, 3'b000, 64'h7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 33, "mul 7x-3", -1);
        @(negedge clk); #1;
        check("mul result one cycle", 64'(u1_alu_o), 64'd4);
        check("mul stall after done", 64'(u1_stall), 64'd0);
        idle(40);

        run_md(0, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 33, "mulhu", -1);  idle(40);
        run_md(0, 3'b001, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 33, "mulh", -1);   idle(40);
        run_md(0, 3'b010, 64'hFFFF_FFFF, 64'h2, 64'hFFFF_FFFF, 33, "mulhsu", -1);         idle(40);
        run_md(0, 3'b100, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD, 33, "div -7/2", -1);       idle(40);
        run_md(0, 3'b110, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFF, 33, "rem -7/2", -1);       idle(40);
        run_md(0, 3'b101, 64'h5, 64'h0, 64'hFFFF_FFFF, 1, "divu 5/0", -1);                idle(40);
        run_md(0, 3'b111, 64'h5, 64'h0, 64'h5, 1, "remu 5/0", -1);                        idle(40);
        run_md(0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1, "div ovf", -1); idle(40);
        run_md(0, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 1, "rem ovf", -1);         idle(40);
        run_md(0, 3'b111, 64'd100, 64'd7, 64'd2, 33, "remu 100/7", -1);                  idle(40);
        run_md(1, 3'b101, 64'd100, 64'd7, 64'd14, 9, "u4 divu 100/7", -1);                idle(40);

        // rs1 comes from EX/MEM; the sources change mid-BUSY.
        fa = 2'b10; me_alu = 32'd6;
        run_md(0, 3'b000, 64'h1234, 64'd5, 64'd30, 33, "fwd latched", 10);
        fa = 2'b00; me_alu = '0;
        idle(40);

        // Flush in the fifth BUSY cycle.
        @(negedge clk);
        md_req = 1'b1; f3 = 3'b000; rd1 = 32'd9; rd2 = 32'd9;
        repeat (5) @(negedge clk);
        #1;
        check("flush pre busy stall", 64'(u1_stall), 64'd1);
        flush = 1'b1;
        #1;
        check("flush stall drop u1", 64'(u1_stall), 64'd0);
        check("flush stall drop u4", 64'(u4_stall), 64'd0);
        @(negedge clk);
        flush = 1'b0; md_req = 1'b0;
        #1;
        check("flush idle stall", 64'(u1_stall), 64'd0);
        check("flush no done", 64'(u1_alu_o), 64'd18);
        idle(3);
        run_md(0, 3'b000, 64'd3, 64'd4, 64'd12, 33, "mul after flush", -1);
        idle(40);

        // Reset pulse in BUSY aborts the operation.
        @(negedge clk);
        md_req = 1'b1; f3 = 3'b000; rd1 = 32'd11; rd2 = 32'd13;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("reset busy stall", 64'(u1_stall), 64'd0);
        md_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (u1_stall !== 1'b0 || u1_alu_o !== 32'd24) bad++;
        end
        check("reset abort quiet", 64'(bad), 64'd0);

        // Branches and ALU.
        @(negedge clk);
        alu_op = 3'd1; f3 = 3'b000; br = 1'b1; fa = 2'b10; fb = 2'b01;
        me_alu = 32'h55; w_data = 32'h55; rd1 = 32'd1; rd2 = 32'd2;
        pc = 32'h100; imm = 32'h20;
        #1;
        check("beq taken", 64'(u1_br_ctrl), 64'd1);
        check("beq target", 64'(u1_br_pc), 64'h120);
        check("store data fwd", 64'(u1_rd2_o), 64'h55);
        f3 = 3'b001; #1;
        check("bne not taken", 64'(u1_br_ctrl), 64'd0);
        f3 = 3'b000; flush = 1'b1; #1;
        check("beq flushed", 64'(u1_br_ctrl), 64'd0);
        flush = 1'b0; fa = 2'b00; fb = 2'b00; rd1 = 32'hFFFF_FFFF; rd2 = 32'd1;
        f3 = 3'b100; #1;
        check("blt taken", 64'(u1_br_ctrl), 64'd1);
        f3 = 3'b110; #1;
        check("bltu not taken", 64'(u1_br_ctrl), 64'd0);

        alu_op = 3'd4; mode = 1'b1; rd1 = 32'h1000; imm = 32'h1; pc = 32'h200;
        src1 = 2'd1; src2 = 2'd2; #1;
        check("jalr target", 64'(u1_br_pc), 64'h1000);
        check("jalr taken", 64'(u1_br_ctrl), 64'd1);
        check("jalr link", 64'(u1_alu_o), 64'h204);

        br = 1'b0; mode = 1'b0; src1 = 2'd0; src2 = 2'd0;
        alu_op = 3'd2; f3 = 3'b000; f7 = 1'b1; rd1 = 32'd10; rd2 = 32'd3; #1;
        check("alu sub", 64'(u1_alu_o), 64'd7);
        f3 = 3'b010; f7 = 1'b0; rd1 = 32'hFFFF_FFFB; #1;
        check("alu slt", 64'(u1_alu_o), 64'd1);
        alu_op = 3'd3; f3 = 3'b101; f7 = 1'b1; src2 = 2'd1; imm = 32'd4; rd1 = 32'h8000_0000; #1;
        check("alu srai", 64'(u1_alu_o), 64'hF800_0000);
        alu_op = 3'd0; f3 = 3'b000; f7 = 1'b0; src2 = 2'd0; imm = '0;
        idle(2);

        // 64-bit datapath.
        run_md(2, 3'b000, 64'h1_0000_0000, 64'h1_0000_0000, 64'h0, 65, "mul64 lo", -1);   idle(5);
        run_md(2, 3'b011, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1, 65, "mulhu64", -1);    idle(5);

        check("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
